// File: rtl/ahbl_apb_bridge_nslv_pkg.sv
// Shared types and AHB encodings for the AHB-Lite to APB4 bridge.
package ahbl_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_apb_bridge_nslv_if.sv
// AHB-Lite slave side plus APB4 master side of the bridge as one bundle.
interface ahbl_apb_bridge_nslv_if #(
    parameter int NUM_SLAVES  = 16,
    parameter int PADDR_WIDTH = 32
) ();
    logic                   HSEL;
    logic [31:0]            HADDR;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [2:0]             HSIZE;
    logic [31:0]            HWDATA;
    logic                   HREADYIN;
    logic                   HREADYOUT;
    logic                   HRESP;
    logic [31:0]            HRDATA;
    logic [NUM_SLAVES-1:0]  PSEL;
    logic [PADDR_WIDTH-1:0] PADDR;
    logic                   PWRITE;
    logic                   PENABLE;
    logic [31:0]            PWDATA;
    logic [3:0]             PSTRB;
    logic [31:0]            PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;

    // Bridge view.
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        output HREADYOUT, HRESP, HRDATA,
        output PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    // AHB master / APB peripheral view.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        input  HREADYOUT, HRESP, HRDATA,
        input  PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ahbl_apb_bridge_nslv_strb_gen.sv
// Byte-strobe generation from AHB size and low address bits; reads give no strobes.
module ahbl_apb_strb_gen
    import ahbl_apb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    input  logic       hwrite,
    output logic [3:0] pstrb
);
    always_comb begin
        pstrb = 4'b0000;
        if (hwrite) begin
            case (hsize)
                HSIZE_BYTE: pstrb = 4'b0001 << addr_lo;
                HSIZE_HALF: pstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                default:    pstrb = 4'b1111;
            endcase
        end
    end
endmodule

// File: rtl/ahbl_apb_bridge_nslv.sv
// AHB-Lite slave to multi-slot APB4 master bridge with two-cycle ERROR response.
// Optional ACCESS-phase timeout is enabled with macro AHBAPB_TIMEOUT_EN.
module ahbl_apb_bridge_nslv
    import ahbl_apb_pkg::*;
#(
    parameter int NUM_SLAVES     = 16,
    parameter int SLOT_LSB       = 8,
    parameter int PADDR_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                 HCLK,
    input logic                 HRESETN,
    ahbl_apb_bridge_nslv_if.slave bus
);
    state_t                state;
    logic [3:0]            slot;
    logic [3:0]            slot_q;
    logic [3:0]            strb;
    logic                  start;
    logic                  mapped;
    logic [NUM_SLAVES-1:0] psel_dec;

    assign slot     = bus.HADDR[SLOT_LSB+3:SLOT_LSB];
    assign start    = bus.HSEL & bus.HREADYIN & htrans_active(bus.HTRANS);
    assign mapped   = (int'(slot) < NUM_SLAVES);
    assign psel_dec = NUM_SLAVES'(1) << slot_q;

    ahbl_apb_strb_gen u_strb (
        .hsize   (bus.HSIZE),
        .addr_lo (bus.HADDR[1:0]),
        .hwrite  (bus.HWRITE),
        .pstrb   (strb)
    );

`ifdef AHBAPB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`endif

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state         <= ST_IDLE;
            slot_q        <= '0;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= HRESP_OKAY;
            bus.HRDATA    <= '0;
            bus.PSEL      <= '0;
            bus.PADDR     <= '0;
            bus.PWRITE    <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWDATA    <= '0;
            bus.PSTRB     <= '0;
`ifdef AHBAPB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    state         <= ST_IDLE;
                    bus.HREADYOUT <= 1'b1;
                    bus.HRESP     <= HRESP_OKAY;
                    if (start) begin
                        bus.HREADYOUT <= 1'b0;
                        if (mapped) begin
                            // APB address-phase signals are frozen here until the next transfer.
                            state      <= ST_LATCH;
                            slot_q     <= slot;
                            bus.PADDR  <= bus.HADDR[PADDR_WIDTH-1:0];
                            bus.PWRITE <= bus.HWRITE;
                            bus.PSTRB  <= strb;
                        end else begin
                            state     <= ST_ERR1;
                            bus.HRESP <= HRESP_ERROR;
                        end
                    end
                end
                ST_LATCH: begin
                    if (bus.PWRITE) bus.PWDATA <= bus.HWDATA;
                    bus.PSEL <= psel_dec;
                    state    <= ST_SETUP;
                end
                ST_SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ST_ACCESS;
`ifdef AHBAPB_TIMEOUT_EN
                    to_cnt      <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (bus.PREADY) begin
                        bus.PSEL    <= '0;
                        bus.PENABLE <= 1'b0;
                        if (bus.PSLVERR) begin
                            state     <= ST_ERR1;
                            bus.HRESP <= HRESP_ERROR;
                        end else begin
                            state         <= ST_DONE;
                            bus.HRDATA    <= bus.PRDATA;
                            bus.HREADYOUT <= 1'b1;
                        end
                    end
`ifdef AHBAPB_TIMEOUT_EN
                    // The abort cycle is itself the last counted wait cycle.
                    else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        bus.PSEL    <= '0;
                        bus.PENABLE <= 1'b0;
                        state       <= ST_ERR1;
                        bus.HRESP   <= HRESP_ERROR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_ERR1: begin
                    state         <= ST_ERR2;
                    bus.HREADYOUT <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.HREADYOUT <= 1'b1;
                    bus.HRESP     <= HRESP_OKAY;
                    bus.PSEL      <= '0;
                    bus.PENABLE   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahbl_apb_bridge_nslv.sv
// Directed bench: a transfer table plus hand sequences for back-to-back, reset and timeout.
module tb_ahbl_apb_bridge_nslv;
    import ahbl_apb_pkg::*;

    logic HCLK;
    logic HRESETN;
    int   n_checks = 0;
    int   n_errors = 0;

    ahbl_apb_bridge_nslv_if #(.NUM_SLAVES(4), .PADDR_WIDTH(32)) bus ();

    ahbl_apb_bridge_nslv #(
        .NUM_SLAVES(4), .SLOT_LSB(8), .PADDR_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic [3:0]  exp_psel;
        logic [3:0]  exp_strb;
        logic        exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/hreadyout"}, 32'(bus.HREADYOUT), 32'd1);
        chk({tag, "/hresp"},     32'(bus.HRESP),     32'd0);
        chk({tag, "/hrdata"},    bus.HRDATA,         32'd0);
        chk({tag, "/psel"},      32'(bus.PSEL),      32'd0);
        chk({tag, "/paddr"},     bus.PADDR,          32'd0);
        chk({tag, "/pwrite"},    32'(bus.PWRITE),    32'd0);
        chk({tag, "/penable"},   32'(bus.PENABLE),   32'd0);
        chk({tag, "/pwdata"},    bus.PWDATA,         32'd0);
        chk({tag, "/pstrb"},     32'(bus.PSTRB),     32'd0);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR  = a;
        bus.HWRITE = w;
        bus.HSIZE  = sz;
    endtask

    task automatic idle_bus();
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
    endtask

    // One transfer; acts as the APB peripheral and records what the bridge drove.
    task automatic run_xfer(input vec_t v);
        int c, acc, pc;
        logic [3:0]  s_psel, s_strb;
        logic [31:0] s_addr, s_wdata;
        logic        s_wr, p_resp, p_rdy, en_ok;
        @(negedge HCLK);
        addr_phase(v.addr, v.write, v.size);
        @(negedge HCLK);
        idle_bus();
        bus.HWDATA = v.wdata;
        c = 1; acc = 0; pc = 0;
        s_psel = '0; s_strb = '0; s_addr = '0; s_wdata = '0; s_wr = 1'b0;
        p_resp = 1'b0; p_rdy = 1'b0; en_ok = 1'b1;
        while (bus.HREADYOUT !== 1'b1 && c < 40) begin
            if (bus.PSEL != '0) begin
                pc++;
                s_psel = bus.PSEL; s_strb = bus.PSTRB; s_addr = bus.PADDR;
                s_wdata = bus.PWDATA; s_wr = bus.PWRITE;
            end
            if (bus.PENABLE) begin
                acc++;
                if (bus.PSEL == '0) en_ok = 1'b0;
            end
            bus.PREADY  = bus.PENABLE && (acc > v.waits);
            bus.PSLVERR = bus.PREADY && v.slverr;
            bus.PRDATA  = v.prdata;
            p_resp = bus.HRESP;
            p_rdy  = bus.HREADYOUT;
            @(negedge HCLK);
            c++;
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        chk({v.name, "/latency"}, 32'(c), 32'(v.exp_lat));
        chk({v.name, "/hresp"},   32'(bus.HRESP), 32'(v.exp_resp));
        chk({v.name, "/psel"},    32'(s_psel), 32'(v.exp_psel));
        if (v.exp_psel != '0) begin
            chk({v.name, "/pstrb"},      32'(s_strb), 32'(v.exp_strb));
            chk({v.name, "/paddr"},      s_addr, v.addr);
            chk({v.name, "/pwrite"},     32'(s_wr), 32'(v.write));
            chk({v.name, "/pen_cycles"}, 32'(acc), 32'(v.waits + 1));
            chk({v.name, "/psel_cycles"}, 32'(pc), 32'(acc + 1));
            chk({v.name, "/pen_no_sel"}, 32'(en_ok), 32'd1);
            if (v.write) chk({v.name, "/pwdata"}, s_wdata, v.wdata);
        end
        if (!v.write && !v.exp_resp) chk({v.name, "/hrdata"}, bus.HRDATA, v.prdata);
        if (v.exp_resp) begin
            chk({v.name, "/err1"}, {30'd0, p_rdy, p_resp}, 32'b01);
            @(negedge HCLK);
            chk({v.name, "/idle_after"}, {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"wr_word_s3",  32'h0000_0310, 1'b1, 3'd2, 32'hA5A5_1234, 32'h0, 0, 1'b0, 4'b1000, 4'b1111, 1'b0, 4};
        vecs[1] = '{"rd_s0_wait2", 32'h0000_0004, 1'b0, 3'd2, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 4'b0001, 4'b0000, 1'b0, 6};
        vecs[2] = '{"wr_byte_a2",  32'h0000_0102, 1'b1, 3'd0, 32'h1122_3344, 32'h0, 0, 1'b0, 4'b0010, 4'b0100, 1'b0, 4};
        vecs[3] = '{"wr_half_hi",  32'h0000_0202, 1'b1, 3'd1, 32'h5566_7788, 32'h0, 0, 1'b0, 4'b0100, 4'b1100, 1'b0, 4};
        vecs[4] = '{"wr_half_lo",  32'h0000_0000, 1'b1, 3'd1, 32'h99AA_BBCC, 32'h0, 0, 1'b0, 4'b0001, 4'b0011, 1'b0, 4};
        vecs[5] = '{"wr_dword",    32'h0000_0301, 1'b1, 3'd3, 32'h0F0F_F0F0, 32'h0, 1, 1'b0, 4'b1000, 4'b1111, 1'b0, 5};
        vecs[6] = '{"wr_slverr",   32'h0000_0100, 1'b1, 3'd2, 32'hCAFE_0001, 32'h0, 0, 1'b1, 4'b0010, 4'b1111, 1'b1, 5};
        vecs[7] = '{"rd_unmap7",   32'h0000_0700, 1'b0, 3'd2, 32'h0, 32'h0, 0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2};
        vecs[8] = '{"rd_s2_wait1", 32'h0000_0208, 1'b0, 3'd2, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 4'b0100, 4'b0000, 1'b0, 5};
        vecs[9] = '{"wr_unmap12",  32'h0000_0C00, 1'b1, 3'd2, 32'h1234_5678, 32'h0, 0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2};

        HRESETN      = 1'b0;
        idle_bus();
        bus.HADDR    = '0;
        bus.HWRITE   = 1'b0;
        bus.HSIZE    = '0;
        bus.HWDATA   = '0;
        bus.HREADYIN = 1'b1;
        bus.PRDATA   = '0;
        bus.PREADY   = 1'b0;
        bus.PSLVERR  = 1'b0;
        #12;
        chk_reset("reset");
        @(negedge HCLK);
        HRESETN = 1'b1;
        @(negedge HCLK);
        chk_reset("post_reset");

        for (int i = 0; i < 10; i++) run_xfer(vecs[i]);

        // BUSY while selected and a NONSEQ with HREADYIN low must not start anything.
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = HTRANS_BUSY; bus.HADDR = 32'h0000_0100;
        @(negedge HCLK);
        chk("busy/hreadyout", 32'(bus.HREADYOUT), 32'd1);
        bus.HTRANS = HTRANS_NONSEQ; bus.HREADYIN = 1'b0;
        @(negedge HCLK);
        chk("nready/hreadyout", 32'(bus.HREADYOUT), 32'd1);
        idle_bus(); bus.HREADYIN = 1'b1;
        @(negedge HCLK);
        chk("nready/psel", 32'(bus.PSEL), 32'd0);

        // Unmapped access followed back-to-back by a read issued during ERR2.
        @(negedge HCLK);
        addr_phase(32'h0000_0700, 1'b0, 3'd2);
        @(negedge HCLK);
        idle_bus();
        chk("b2b/err1", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b01);
        @(negedge HCLK);
        chk("b2b/err2", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b11);
        chk("b2b/err_psel", 32'(bus.PSEL), 32'd0);
        addr_phase(32'h0000_0108, 1'b0, 3'd2);
        @(negedge HCLK);
        idle_bus();
        chk("b2b/latch", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b00);
        @(negedge HCLK);
        chk("b2b/setup", {28'd0, bus.PSEL}, 32'b0010);
        chk("b2b/setup_pen", 32'(bus.PENABLE), 32'd0);
        @(negedge HCLK);
        chk("b2b/access_pen", 32'(bus.PENABLE), 32'd1);
        bus.PREADY = 1'b1; bus.PRDATA = 32'h1234_5678;
        @(negedge HCLK);
        bus.PREADY = 1'b0;
        chk("b2b/done", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b10);
        chk("b2b/hrdata", bus.HRDATA, 32'h1234_5678);
        chk("b2b/psel_drop", 32'(bus.PSEL), 32'd0);

`ifdef AHBAPB_TIMEOUT_EN
        begin
            int pen, k;
            @(negedge HCLK);
            addr_phase(32'h0000_0300, 1'b0, 3'd2);
            @(negedge HCLK);
            idle_bus();
            pen = 0; k = 0;
            while (bus.HRESP !== 1'b1 && k < 30) begin
                if (bus.PENABLE) pen++;
                @(negedge HCLK);
                k++;
            end
            chk("tmo/access_cycles", 32'(pen), 32'd8);
            chk("tmo/err1", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b01);
            chk("tmo/pen_drop", 32'(bus.PENABLE), 32'd0);
            chk("tmo/psel_drop", 32'(bus.PSEL), 32'd0);
            bus.PREADY = 1'b1;
            @(negedge HCLK);
            bus.PREADY = 1'b0;
            chk("tmo/err2", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b11);
            @(negedge HCLK);
            chk("tmo/idle", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b10);
        end
`endif

        // Reset asserted mid-ACCESS clears everything without a clock edge.
        @(negedge HCLK);
        addr_phase(32'h0000_0208, 1'b1, 3'd2);
        @(negedge HCLK);
        idle_bus();
        bus.HWDATA = 32'h7777_8888;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("rst_mid/in_access", 32'(bus.PENABLE), 32'd1);
        #2 HRESETN = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge HCLK);
        HRESETN = 1'b1;
        @(negedge HCLK);
        chk("rst_mid/idle", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'b10);
        chk("rst_mid/no_psel", 32'(bus.PSEL), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ahbl_apb_bridge_nslv.md
# ahbl_apb_bridge_nslv

Parametrised AHB-Lite slave to APB4 master bridge used by the BFM wrapper layer and by subsystem fabrics to reach up to 16 APB peripherals. It replaces the fixed single-slot, 32-bit bridge with:
- configurable slot count, slot decode position and APB address width;
- PSTRB generation from HSIZE;
- a two-cycle AHB ERROR response for PSLVERR and for unmapped slots;
- an optional access timeout.

## Interface
Parameters:
- NUM_SLAVES, 16, number of APB slots (1..16); PSEL width.
- SLOT_LSB, 8, lowest HADDR bit of the 4-bit slot index.
- PADDR_WIDTH, 32, width of PADDR (8..32); PADDR = captured HADDR[PADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 255, ACCESS-phase cycle limit (used only with AHBAPB_TIMEOUT_EN).

Ports:
- HCLK  in  1  clock; all logic rising-edge.
- HRESETN  in  1  reset; asynchronous assert, active-low.
- HSEL  in  1  bridge select.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; NONSEQ/SEQ start a transfer.
- HWRITE  in  1  direction.
- HSIZE  in  3  byte/half/word; larger sizes are treated as word.
- HWDATA  in  32  write data.
- HREADYIN  in  1  bus-level HREADY.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PADDR  out  PADDR_WIDTH  APB address.
- PWRITE  out  1  direction.
- PENABLE  out  1  access phase.
- PWDATA  out  32  write data.
- PSTRB  out  4  byte strobes.
- PRDATA  in  32  read data.
- PREADY  in  1  wait control.
- PSLVERR  in  1  slave error.

## Operation
Start condition: a transfer is sampled on a rising edge when HSEL & HREADYIN & HTRANS[1] are all 1. This is checked only in IDLE, DONE and ERR2.

On a sampled transfer the bridge captures HADDR, HWRITE, HSIZE, and the slot index HADDR[SLOT_LSB+3:SLOT_LSB].
- slot < NUM_SLAVES: go to LATCH.
- otherwise: go to ERR1; no APB activity.

FSM states:
- IDLE: HREADYOUT=1, HRESP=0.
- LATCH: HREADYOUT=0. HWDATA is registered into PWDATA at the end of this cycle (writes only). Next: SETUP.
- SETUP: the PSEL bit for the slot is 1, PENABLE=0. Next: ACCESS.
- ACCESS: PENABLE=1.
  - PREADY=0: stay.
  - PREADY=1 and PSLVERR=0: register PRDATA into HRDATA; next DONE.
  - PREADY=1 and PSLVERR=1: next ERR1.
  - PSEL and PENABLE drop on leaving ACCESS.
- DONE: HREADYOUT=1, HRESP=0. Next: LATCH or ERR1 if a new transfer is sampled, else IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Next: ERR2.
- ERR2: HREADYOUT=1, HRESP=1. Next: same as DONE.

PSTRB:
- Reads: 0000.
- Byte writes: one-hot at HADDR[1:0].
- Halfword writes: 0011 or 1100 by HADDR[1].
- Word writes: 1111.

PADDR, PWRITE and PSTRB are held constant from SETUP through the end of ACCESS. HRDATA holds its last value otherwise.

Reset values: HREADYOUT=1; HRESP=0; HRDATA=0; PSEL=0; PADDR=0; PWRITE=0; PENABLE=0; PWDATA=0; PSTRB=0; state IDLE. Asserting reset mid-transfer aborts it immediately; no ERROR response is produced.

## Timing
- Address phase ends at edge 0. Then: LATCH in cycle 1, SETUP in cycle 2, ACCESS from cycle 3, HREADYOUT=1 in cycle 4 when PREADY=1 in cycle 3.
- Minimum AHB data phase is 4 cycles; each PREADY=0 cycle adds one.
- Error path: ERR1 and ERR2 occupy the last 2 cycles. An unmapped slot gives HRESP=1 in cycles 1–2 with HREADYOUT=1 in cycle 2.
- Back-to-back transfers: a transfer sampled in DONE or ERR2 enters LATCH on the next cycle, with no IDLE gap.
- HTRANS IDLE/BUSY while selected causes no state change.

## Configuration
Macro: AHBAPB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, the access is abandoned: PSEL and PENABLE drop and the FSM goes to ERR1.
  - A PREADY arriving after the abort is ignored.
- Not defined: the counter is absent, the bridge waits on PREADY indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- Package ahbl_apb_pkg holds:
  - the FSM state enum;
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE encodings;
  - HRESP OKAY/ERROR constants.
- One sub-module, ahbl_apb_strb_gen: combinational mapping of HSIZE, HADDR[1:0] and HWRITE to PSTRB, instantiated once.

## Test plan
- Word write 0xA5A5_1234 to slot 3, offset 0x10, PREADY=1: PSEL=0x0008 in cycles 2–3, PENABLE only in cycle 3, PSTRB=1111, HREADYOUT=1 in cycle 4, HRESP=0.
- Read slot 0 with PREADY low for 2 cycles, PRDATA=0xDEAD_BEEF: HREADYOUT=1 in cycle 6 with HRDATA=0xDEAD_BEEF.
- Byte write at HADDR[1:0]=2, then halfword write at HADDR[1]=1: PSTRB=0100, then 1100.
- PSLVERR=1 on a write: HRESP=1, HREADYOUT=0 for one cycle, then HRESP=1, HREADYOUT=1; then IDLE.
- With NUM_SLAVES=4, access slot 7: PSEL stays 0, two-cycle ERROR response starting cycle 1. A following back-to-back valid read completes normally.
- With AHBAPB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, hold PREADY=0: PENABLE drops after 8 ACCESS cycles, then the ERROR response. Assert HRESETN low mid-ACCESS in a separate run: all outputs return to reset values asynchronously.
